// File: rtl/d_cache_tag_array_if.sv
// -----------------------------------------------------------------------------
// d_cache_tag_array_if
// Bundle of lookup, response, tag-write and flush signals between the D-cache
// controller (master) and the tag store (slave).
//   lookup   : lkp_valid, lkp_idx, lkp_tag  -> lkp_ready
//   response : rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_victim,
//              rsp_victim_dirty
//   write    : wr_en, wr_idx, wr_way, wr_tag, wr_valid, wr_dirty
//   flush    : flush_req -> flush_busy
// Optional: err_multihit, present only when D_CACHE_TAG_MULTIHIT_CHECK_EN
// is defined.
// -----------------------------------------------------------------------------
interface d_cache_tag_array_if #(
    parameter int WAY_W = 2,
    parameter int IDX_W = 6,
    parameter int TAG_W = 55
);
    logic             lkp_valid;
    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic             lkp_ready;

    logic             rsp_valid;
    logic             rsp_hit;
    logic [WAY_W-1:0] rsp_way;
    logic             rsp_dirty;
    logic [WAY_W-1:0] rsp_victim;
    logic             rsp_victim_dirty;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WAY_W-1:0] wr_way;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_valid;
    logic             wr_dirty;

    logic             flush_req;
    logic             flush_busy;

`ifdef D_CACHE_TAG_MULTIHIT_CHECK_EN
    logic             err_multihit;
`endif

    modport master (
        output lkp_valid, lkp_idx, lkp_tag,
        output wr_en, wr_idx, wr_way, wr_tag, wr_valid, wr_dirty,
        output flush_req,
        input  lkp_ready,
        input  rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_victim, rsp_victim_dirty,
        input  flush_busy
`ifdef D_CACHE_TAG_MULTIHIT_CHECK_EN
        , input err_multihit
`endif
    );

    modport slave (
        input  lkp_valid, lkp_idx, lkp_tag,
        input  wr_en, wr_idx, wr_way, wr_tag, wr_valid, wr_dirty,
        input  flush_req,
        output lkp_ready,
        output rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_victim, rsp_victim_dirty,
        output flush_busy
`ifdef D_CACHE_TAG_MULTIHIT_CHECK_EN
        , output err_multihit
`endif
    );
endinterface

// File: rtl/d_cache_tag_array.sv
// -----------------------------------------------------------------------------
// d_cache_tag_array
// N-way set-associative tag store for the data cache. Per set and way it keeps
// a tag, a valid bit and a dirty bit, plus a per-set round-robin pointer used
// as the replacement victim once every way is valid.
//   clk   : clock, all state changes on posedge
//   rst   : synchronous active-high reset; starts the invalidate sweep
//   bus   : d_cache_tag_array_if.slave (lookup, response, write, flush)
// Lookups are accepted when lkp_valid && lkp_ready and answered one cycle
// later with a single-cycle rsp_valid pulse; response fields hold otherwise.
// A same-cycle write to the looked-up set is not visible to that lookup.
// After reset or a flush, SETS cycles of sweep clear valid/dirty/rr for one
// set per cycle; tags are left untouched.
// Optional feature macro: D_CACHE_TAG_MULTIHIT_CHECK_EN adds the sticky
// bus.err_multihit flag (more than one way hit in a lookup).
// -----------------------------------------------------------------------------
module d_cache_tag_array #(
    parameter int WAYS  = 4,
    parameter int WAY_W = 2,
    parameter int IDX_W = 6,
    parameter int TAG_W = 55
) (
    input  logic                clk,
    input  logic                rst,
    d_cache_tag_array_if.slave  bus
);
    localparam int SETS = 1 << IDX_W;

    typedef enum logic {
        ST_SWEEP,
        ST_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;

    // Storage: valid/dirty/rr are swept; tags are only ever written by wr_en.
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];
    logic [TAG_W-1:0] tag_mem [WAYS][SETS];

    logic             lkp_ready;
    logic             accept;
    logic             wr_fire;
    logic             sweep_last;

    always_comb begin
        lkp_ready  = (state_q == ST_IDLE) && !bus.flush_req;
        accept     = bus.lkp_valid && lkp_ready;
        wr_fire    = bus.wr_en && lkp_ready;
        sweep_last = (state_q == ST_SWEEP) && (sweep_cnt_q == IDX_W'(SETS - 1));
    end

    assign bus.lkp_ready  = lkp_ready;
    assign bus.flush_busy = (state_q == ST_SWEEP);

    // ------------------------------------------------------------------
    // Sweep / idle FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            ST_SWEEP: begin
                sweep_cnt_d = sweep_cnt_q + 1'b1;
                if (sweep_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = '0;
                end
            end
            default: state_d = ST_SWEEP;
        endcase
    end

    // ------------------------------------------------------------------
    // Lookup datapath (reads the pre-write contents of the indexed set)
    // ------------------------------------------------------------------
    logic [WAYS-1:0]  set_valid;
    logic [WAYS-1:0]  set_dirty;
    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim_way;
    logic             victim_dirty;

    always_comb begin
        set_valid = valid_q[bus.lkp_idx];
        set_dirty = dirty_q[bus.lkp_idx];
        hit_vec   = '0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = set_valid[w] && (tag_mem[w][bus.lkp_idx] == bus.lkp_tag);
        end
        // Walk from the top so the lowest-numbered candidate wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_way   = inv_found ? inv_way : rr_q[bus.lkp_idx];
        victim_dirty = set_valid[victim_way] && set_dirty[victim_way];
    end

    // ------------------------------------------------------------------
    // Response registers: loaded on an accepted lookup, held otherwise
    // ------------------------------------------------------------------
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_hit_q, rsp_hit_d;
    logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
    logic             rsp_dirty_q, rsp_dirty_d;
    logic [WAY_W-1:0] rsp_victim_q, rsp_victim_d;
    logic             rsp_victim_dirty_q, rsp_victim_dirty_d;

    always_comb begin
        rsp_valid_d        = accept;
        rsp_hit_d          = rsp_hit_q;
        rsp_way_d          = rsp_way_q;
        rsp_dirty_d        = rsp_dirty_q;
        rsp_victim_d       = rsp_victim_q;
        rsp_victim_dirty_d = rsp_victim_dirty_q;
        if (accept) begin
            rsp_hit_d          = |hit_vec;
            rsp_way_d          = hit_way;
            rsp_dirty_d        = (|hit_vec) && set_dirty[hit_way];
            rsp_victim_d       = victim_way;
            rsp_victim_dirty_d = victim_dirty;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            state_q            <= ST_SWEEP;
            sweep_cnt_q        <= '0;
            rsp_valid_q        <= 1'b0;
            rsp_hit_q          <= 1'b0;
            rsp_way_q          <= '0;
            rsp_dirty_q        <= 1'b0;
            rsp_victim_q       <= '0;
            rsp_victim_dirty_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            sweep_cnt_q        <= sweep_cnt_d;
            rsp_valid_q        <= rsp_valid_d;
            rsp_hit_q          <= rsp_hit_d;
            rsp_way_q          <= rsp_way_d;
            rsp_dirty_q        <= rsp_dirty_d;
            rsp_victim_q       <= rsp_victim_d;
            rsp_victim_dirty_q <= rsp_victim_dirty_d;
        end
    end

    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_hit          = rsp_hit_q;
    assign bus.rsp_way          = rsp_way_q;
    assign bus.rsp_dirty        = rsp_dirty_q;
    assign bus.rsp_victim       = rsp_victim_q;
    assign bus.rsp_victim_dirty = rsp_victim_dirty_q;

    // ------------------------------------------------------------------
    // Storage update: sweep clear or way-addressed write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the arrays have no reset branch; the post-reset sweep clears
        // valid/dirty/rr before any lookup can be accepted, and tags are
        // meaningless while their valid bit is clear.
        if (!rst) begin
            if (state_q == ST_SWEEP) begin
                valid_q[sweep_cnt_q] <= '0;
                dirty_q[sweep_cnt_q] <= '0;
                rr_q[sweep_cnt_q]    <= '0;
            end else if (wr_fire) begin
                valid_q[bus.wr_idx][bus.wr_way] <= bus.wr_valid;
                dirty_q[bus.wr_idx][bus.wr_way] <= bus.wr_dirty;
                tag_mem[bus.wr_way][bus.wr_idx] <= bus.wr_tag;
                if (bus.wr_valid) begin
                    // Wraps naturally because WAYS == 2**WAY_W.
                    rr_q[bus.wr_idx] <= bus.wr_way + WAY_W'(1);
                end
            end
        end
    end

`ifdef D_CACHE_TAG_MULTIHIT_CHECK_EN
    // ------------------------------------------------------------------
    // Sticky multi-hit flag, cleared by reset or a completed sweep
    // ------------------------------------------------------------------
    logic err_multihit_q, err_multihit_d;
    logic multi_hit;

    always_comb begin
        // More than one bit set <=> clearing the lowest set bit leaves some.
        multi_hit      = |(hit_vec & (hit_vec - WAYS'(1)));
        err_multihit_d = err_multihit_q;
        if (sweep_last) begin
            err_multihit_d = 1'b0;
        end else if (accept && multi_hit) begin
            err_multihit_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_multihit_q <= 1'b0;
        end else begin
            err_multihit_q <= err_multihit_d;
        end
    end

    assign bus.err_multihit = err_multihit_q;
`endif

endmodule

// File: tb/tb_d_cache_tag_array.sv
// -----------------------------------------------------------------------------
// tb_d_cache_tag_array
// Self-checking bench for d_cache_tag_array: directed steps followed by a
// randomized phase, compared every cycle against an array-based reference
// model of the tag store, plus directed checks with literal expected values.
// -----------------------------------------------------------------------------
module tb_d_cache_tag_array;
    localparam int WAYS  = 4;
    localparam int WAY_W = 2;
    localparam int IDX_W = 6;
    localparam int TAG_W = 55;
    localparam int SETS  = 1 << IDX_W;

    logic clk;
    logic rst;

    d_cache_tag_array_if #(.WAY_W(WAY_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

    d_cache_tag_array #(
        .WAYS (WAYS),
        .WAY_W(WAY_W),
        .IDX_W(IDX_W),
        .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit               m_valid [WAYS][SETS];
    bit               m_dirty [WAYS][SETS];
    logic [TAG_W-1:0] m_tag   [WAYS][SETS];
    int               m_rr    [SETS];
    bit               m_sweeping;
    int               m_cnt;
    bit               e_valid, e_hit, e_dirty, e_vdirty, e_err;
    int               e_way, e_victim;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup();
        int idx;
        int nh;
        int inv;
        idx   = int'(bus.lkp_idx);
        nh    = 0;
        inv   = -1;
        e_way = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[w][idx] && m_tag[w][idx] == bus.lkp_tag) begin
                if (nh == 0) e_way = w;
                nh++;
            end
            if (!m_valid[w][idx] && inv < 0) inv = w;
        end
        e_hit    = (nh > 0);
        e_dirty  = (nh > 0) && m_dirty[e_way][idx];
        e_victim = (inv >= 0) ? inv : m_rr[idx];
        e_vdirty = m_valid[e_victim][idx] && m_dirty[e_victim][idx];
        if (nh > 1) e_err = 1'b1;
        e_valid  = 1'b1;
    endtask

    // Advances the model by one clock using the inputs as they stand now.
    task automatic model_step();
        bit ready;
        if (rst) begin
            m_sweeping = 1'b1;
            m_cnt      = 0;
            e_valid    = 1'b0;
            e_hit      = 1'b0;
            e_dirty    = 1'b0;
            e_vdirty   = 1'b0;
            e_err      = 1'b0;
            e_way      = 0;
            e_victim   = 0;
            return;
        end
        ready   = !m_sweeping && !bus.flush_req;
        e_valid = 1'b0;
        if (m_sweeping) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[w][m_cnt] = 1'b0;
                m_dirty[w][m_cnt] = 1'b0;
            end
            m_rr[m_cnt] = 0;
            m_cnt++;
            if (m_cnt == SETS) begin
                m_sweeping = 1'b0;
                e_err      = 1'b0;
            end
        end else begin
            if (bus.lkp_valid && ready) model_lookup();
            if (bus.wr_en && ready) begin
                m_valid[bus.wr_way][bus.wr_idx] = bus.wr_valid;
                m_dirty[bus.wr_way][bus.wr_idx] = bus.wr_dirty;
                m_tag[bus.wr_way][bus.wr_idx]   = bus.wr_tag;
                if (bus.wr_valid) m_rr[bus.wr_idx] = (int'(bus.wr_way) + 1) % WAYS;
            end
            if (bus.flush_req) begin
                m_sweeping = 1'b1;
                m_cnt      = 0;
            end
        end
    endtask

    // One clock: update model, let the edge happen, compare 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("flush_busy", 64'(bus.flush_busy), 64'(m_sweeping));
        check("lkp_ready", 64'(bus.lkp_ready), 64'(!m_sweeping && !bus.flush_req));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(e_valid));
        check("rsp_hit", 64'(bus.rsp_hit), 64'(e_hit));
        check("rsp_way", 64'(bus.rsp_way), 64'(e_way));
        check("rsp_dirty", 64'(bus.rsp_dirty), 64'(e_dirty));
        check("rsp_victim", 64'(bus.rsp_victim), 64'(e_victim));
        check("rsp_victim_dirty", 64'(bus.rsp_victim_dirty), 64'(e_vdirty));
`ifdef D_CACHE_TAG_MULTIHIT_CHECK_EN
        check("err_multihit", 64'(bus.err_multihit), 64'(e_err));
`endif
    endtask

    task automatic clear_inputs();
        bus.lkp_valid = 1'b0;
        bus.lkp_idx   = '0;
        bus.lkp_tag   = '0;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_way    = '0;
        bus.wr_tag    = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_dirty  = 1'b0;
        bus.flush_req = 1'b0;
    endtask

    task automatic set_lookup(input int idx, input longint tag);
        bus.lkp_valid = 1'b1;
        bus.lkp_idx   = IDX_W'(idx);
        bus.lkp_tag   = TAG_W'(tag);
    endtask

    task automatic set_write(input int idx, input int way, input longint tag, input bit v, input bit d);
        bus.wr_en    = 1'b1;
        bus.wr_idx   = IDX_W'(idx);
        bus.wr_way   = WAY_W'(way);
        bus.wr_tag   = TAG_W'(tag);
        bus.wr_valid = v;
        bus.wr_dirty = d;
    endtask

    task automatic lookup(input int idx, input longint tag);
        set_lookup(idx, tag);
        tick();
        clear_inputs();
    endtask

    task automatic write(input int idx, input int way, input longint tag, input bit v, input bit d);
        set_write(idx, way, tag, v, d);
        tick();
        clear_inputs();
    endtask

    // Counts cycles with flush_busy high, bounded so a stuck sweep cannot hang.
    task automatic wait_sweep(output int n);
        n = 0;
        while (bus.flush_busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic pulse_flush();
        bus.flush_req = 1'b1;
        #1;
        check("flush_ready_low", 64'(bus.lkp_ready), 64'(0));
        tick();
        bus.flush_req = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        clear_inputs();

        // Reset for 3 cycles, then the post-reset sweep.
        repeat (3) tick();
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_busy", 64'(bus.flush_busy), 64'(1));
        check("rst_ready", 64'(bus.lkp_ready), 64'(0));
        rst = 1'b0;
        wait_sweep(n);
        check("reset_sweep_len", 64'(n), 64'(64));
        check("ready_after_sweep", 64'(bus.lkp_ready), 64'(1));

        lookup(5, 0);
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        check("t1_hit", 64'(bus.rsp_hit), 64'(0));
        check("t1_victim", 64'(bus.rsp_victim), 64'(0));

        // Write then hit / miss.
        write(5, 2, 64'h1234, 1'b1, 1'b1);
        lookup(5, 64'h1234);
        check("t2_hit", 64'(bus.rsp_hit), 64'(1));
        check("t2_way", 64'(bus.rsp_way), 64'(2));
        check("t2_dirty", 64'(bus.rsp_dirty), 64'(1));
        lookup(5, 64'h1235);
        check("t2_miss", 64'(bus.rsp_hit), 64'(0));
        check("t2_miss_victim", 64'(bus.rsp_victim), 64'(0));

        // Same-cycle write and lookup: read-first.
        set_write(9, 0, 64'hAA, 1'b1, 1'b0);
        set_lookup(9, 64'hAA);
        tick();
        clear_inputs();
        check("t3_readfirst_hit", 64'(bus.rsp_hit), 64'(0));
        lookup(9, 64'hAA);
        check("t3_after_hit", 64'(bus.rsp_hit), 64'(1));
        check("t3_after_way", 64'(bus.rsp_way), 64'(0));

        // Fill set 7, round-robin victim.
        for (int w = 0; w < WAYS; w++) write(7, w, 64'h700 + w, 1'b1, 1'b0);
        lookup(7, 64'h7FF);
        check("t4_victim_rr0", 64'(bus.rsp_victim), 64'(0));
        check("t4_vdirty0", 64'(bus.rsp_victim_dirty), 64'(0));
        write(7, 0, 64'h700, 1'b1, 1'b1);
        lookup(7, 64'h7FF);
        check("t4_victim_rr1", 64'(bus.rsp_victim), 64'(1));
        tick();
        check("t4_hold_valid", 64'(bus.rsp_valid), 64'(0));
        check("t4_hold_victim", 64'(bus.rsp_victim), 64'(1));

        // Flush; writes during the sweep are ignored.
        pulse_flush();
        set_write(7, 1, 64'hBEEF, 1'b1, 1'b1);
        repeat (3) tick();
        clear_inputs();
        wait_sweep(n);
        check("flush_sweep_len", 64'(n + 3), 64'(64));
        lookup(7, 64'h701);
        check("t5_miss", 64'(bus.rsp_hit), 64'(0));
        check("t5_victim", 64'(bus.rsp_victim), 64'(0));
        lookup(7, 64'hBEEF);
        check("t5_sweep_write_ignored", 64'(bus.rsp_hit), 64'(0));
        lookup(5, 64'h1234);
        check("t5_miss5", 64'(bus.rsp_hit), 64'(0));

        // Reset 20 cycles into a sweep restarts it.
        pulse_flush();
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_sweep(n);
        check("restart_sweep_len", 64'(n), 64'(64));

`ifdef D_CACHE_TAG_MULTIHIT_CHECK_EN
        check("mh_initial", 64'(bus.err_multihit), 64'(0));
        write(2, 1, 64'h55, 1'b1, 1'b0);
        write(2, 3, 64'h55, 1'b1, 1'b0);
        lookup(2, 64'h55);
        check("mh_way", 64'(bus.rsp_way), 64'(1));
        check("mh_err", 64'(bus.err_multihit), 64'(1));
        lookup(2, 64'h56);
        repeat (3) tick();
        check("mh_sticky", 64'(bus.err_multihit), 64'(1));
        pulse_flush();
        check("mh_during_sweep", 64'(bus.err_multihit), 64'(1));
        wait_sweep(n);
        check("mh_cleared", 64'(bus.err_multihit), 64'(0));
`endif

        // Randomized traffic against the model; small tag/index space forces hits.
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 999) == 0);
            bus.lkp_valid = 1'($urandom_range(0, 1));
            bus.lkp_idx   = IDX_W'($urandom_range(0, 3));
            bus.lkp_tag   = TAG_W'($urandom_range(0, 7));
            bus.wr_en     = ($urandom_range(0, 2) == 0);
            bus.wr_idx    = IDX_W'($urandom_range(0, 3));
            bus.wr_way    = WAY_W'($urandom_range(0, WAYS - 1));
            bus.wr_tag    = TAG_W'($urandom_range(0, 7));
            bus.wr_valid  = ($urandom_range(0, 3) != 0);
            bus.wr_dirty  = 1'($urandom_range(0, 1));
            bus.flush_req = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
